// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module   : vga_timing_gen
// Brief    : VGA raster timing (pixel tick, h/v sync, blanking, x/y, strobes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen #(
  parameter int       CLK_DIV   = 2,
  parameter int       H_DISPLAY = 640,
  parameter int       H_FRONT   = 16,
  parameter int       H_SYNC    = 96,
  parameter int       H_BACK    = 48,
  parameter int       V_DISPLAY = 480,
  parameter int       V_FRONT   = 10,
  parameter int       V_SYNC    = 2,
  parameter int       V_BACK    = 33,
  parameter logic     HS_POL    = 1'b0,
  parameter logic     VS_POL    = 1'b0,
  parameter int       CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             pix_tick,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic             tick;
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  generate
    if (CLK_DIV > 1) begin : g_div
      localparam int               DIV_W    = $clog2(CLK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

      logic [DIV_W-1:0] div_cnt_q, div_cnt_d;

      always_comb begin
        div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          div_cnt_q <= '0;
        end else begin
          div_cnt_q <= div_cnt_d;
        end
      end

      assign tick = (div_cnt_q == DIV_LAST);
    end else begin : g_nodiv
      assign tick = 1'b1;
    end
  endgenerate

  // Vertical counter only moves on the pixel where the line wraps.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + CNT_W'(1);
      end else begin
        h_cnt_d = h_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  // Outputs sample the pre-update counters, so they all lag by one clk together.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_tick    <= 1'b0;
      x           <= '0;
      y           <= '0;
      video_on    <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick;
      x           <= h_cnt_q;
      y           <= v_cnt_q;
      video_on    <= (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
      hsync       <= ((h_cnt_q >= HS_START) && (h_cnt_q < HS_END)) ? HS_POL : ~HS_POL;
      vsync       <= ((v_cnt_q >= VS_START) && (v_cnt_q < VS_END)) ? VS_POL : ~VS_POL;
      line_start  <= tick && (h_cnt_q == '0);
      frame_start <= tick && (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module   : tb_vga_timing_gen
// Brief    : Directed bench for vga_timing_gen on three parameter sets.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

  logic clk;
  logic rst0, rst1, rst2;

  // dut0: defaults (CLK_DIV=2, 640x480)
  logic       d0_pt, d0_hs, d0_vs, d0_vid, d0_ls, d0_fs;
  logic [9:0] d0_x, d0_y;
  // dut1: CLK_DIV=1, default horizontal, 8-line frame
  logic       d1_pt, d1_hs, d1_vs, d1_vid, d1_ls, d1_fs;
  logic [9:0] d1_x, d1_y;
  // dut2: tiny raster, CLK_DIV=3, HS_POL=1
  logic       d2_pt, d2_hs, d2_vs, d2_vid, d2_ls, d2_fs;
  logic [9:0] d2_x, d2_y;

  vga_timing_gen u_dut0 (
    .clk(clk), .reset(rst0), .pix_tick(d0_pt), .hsync(d0_hs), .vsync(d0_vs),
    .video_on(d0_vid), .x(d0_x), .y(d0_y), .line_start(d0_ls), .frame_start(d0_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_dut1 (
    .clk(clk), .reset(rst1), .pix_tick(d1_pt), .hsync(d1_hs), .vsync(d1_vs),
    .video_on(d1_vid), .x(d1_x), .y(d1_y), .line_start(d1_ls), .frame_start(d1_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_DISPLAY(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .HS_POL(1'b1)
  ) u_dut2 (
    .clk(clk), .reset(rst2), .pix_tick(d2_pt), .hsync(d2_hs), .vsync(d2_vs),
    .video_on(d2_vid), .x(d2_x), .y(d2_y), .line_start(d2_ls), .frame_start(d2_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int ls_n, fs_n, vid_n, hs_n, vs_n;
  int hs_xmin, hs_xmax, vs_ymin, vs_ymax, vid_xmax, vid_ymax;
  int xmax, ymax, lastx, lasty, run, bad_runs, prevx;
  bit found;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_tallies();
    ls_n = 0; fs_n = 0; vid_n = 0; hs_n = 0; vs_n = 0;
    hs_xmin = 9999; hs_xmax = -1; vs_ymin = 9999; vs_ymax = -1;
    vid_xmax = -1; vid_ymax = -1; xmax = -1; ymax = -1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (5) step();

    // ---------------- reset state (defaults) ----------------
    check("rst_hsync",    32'(d0_hs),  32'd1);
    check("rst_vsync",    32'(d0_vs),  32'd1);
    check("rst_video_on", 32'(d0_vid), 32'd0);
    check("rst_x",        32'(d0_x),   32'd0);
    check("rst_y",        32'(d0_y),   32'd0);
    check("rst_frame_st", 32'(d0_fs),  32'd0);
    check("rst_line_st",  32'(d0_ls),  32'd0);
    check("rst_pix_tick", 32'(d0_pt),  32'd0);

    // ---------------- release: first frame_start 2 clks later ----------------
    rst0 = 1'b0;
    step();
    check("rel1_frame_st", 32'(d0_fs), 32'd0);
    check("rel1_pix_tick", 32'(d0_pt), 32'd0);
    step();
    check("rel2_frame_st", 32'(d0_fs),  32'd1);
    check("rel2_line_st",  32'(d0_ls),  32'd1);
    check("rel2_pix_tick", 32'(d0_pt),  32'd1);
    check("rel2_video_on", 32'(d0_vid), 32'd1);
    step();
    check("rel3_frame_st", 32'(d0_fs), 32'd0);
    check("rel3_x",        32'(d0_x),  32'd1);
    step();
    check("rel4_x",        32'(d0_x),  32'd1);
    check("rel4_pix_tick", 32'(d0_pt), 32'd1);

    // one full line at CLK_DIV=2: 1600 clks starting at the 2nd clk of x=1
    clear_tallies();
    for (int i = 0; i < 1600; i++) begin
      if (d0_ls) ls_n++;
      if (d0_vid) vid_n++;
      if (!d0_hs) begin
        hs_n++;
        if (int'(d0_x) < hs_xmin) hs_xmin = int'(d0_x);
        if (int'(d0_x) > hs_xmax) hs_xmax = int'(d0_x);
      end
      if (int'(d0_x) > xmax) xmax = int'(d0_x);
      step();
    end
    check("d0_line_st_cnt", 32'(ls_n),    32'd1);
    check("d0_video_clks",  32'(vid_n),   32'd1280);
    check("d0_hsync_clks",  32'(hs_n),    32'd192);
    check("d0_hsync_xmin",  32'(hs_xmin), 32'd656);
    check("d0_hsync_xmax",  32'(hs_xmax), 32'd751);
    check("d0_x_max",       32'(xmax),    32'd799);
    check("d0_y_line1",     32'(d0_y),    32'd1);

    // ---------------- CLK_DIV=1, full 8-line frame ----------------
    rst1 = 1'b0;
    step();
    check("d1_first_frame_st", 32'(d1_fs), 32'd1);
    clear_tallies();
    lastx = 0; lasty = 0;
    for (int i = 0; i < 6400; i++) begin
      if (d1_ls) ls_n++;
      if (d1_fs) fs_n++;
      if (d1_vid) begin
        vid_n++;
        if (int'(d1_x) > vid_xmax) vid_xmax = int'(d1_x);
        if (int'(d1_y) > vid_ymax) vid_ymax = int'(d1_y);
      end
      if (!d1_hs) begin
        hs_n++;
        if (int'(d1_x) < hs_xmin) hs_xmin = int'(d1_x);
        if (int'(d1_x) > hs_xmax) hs_xmax = int'(d1_x);
      end
      if (!d1_vs) begin
        vs_n++;
        if (int'(d1_y) < vs_ymin) vs_ymin = int'(d1_y);
        if (int'(d1_y) > vs_ymax) vs_ymax = int'(d1_y);
      end
      if (int'(d1_x) > xmax) xmax = int'(d1_x);
      if (int'(d1_y) > ymax) ymax = int'(d1_y);
      lastx = int'(d1_x);
      lasty = int'(d1_y);
      step();
    end
    check("d1_line_st_cnt",  32'(ls_n),     32'd8);
    check("d1_frame_st_cnt", 32'(fs_n),     32'd1);
    check("d1_video_clks",   32'(vid_n),    32'd2560);
    check("d1_video_xmax",   32'(vid_xmax), 32'd639);
    check("d1_video_ymax",   32'(vid_ymax), 32'd3);
    check("d1_hsync_clks",   32'(hs_n),     32'd768);
    check("d1_hsync_xmin",   32'(hs_xmin),  32'd656);
    check("d1_hsync_xmax",   32'(hs_xmax),  32'd751);
    check("d1_vsync_clks",   32'(vs_n),     32'd1600);
    check("d1_vsync_ymin",   32'(vs_ymin),  32'd5);
    check("d1_vsync_ymax",   32'(vs_ymax),  32'd6);
    check("d1_x_max",        32'(xmax),     32'd799);
    check("d1_y_max",        32'(ymax),     32'd7);
    check("d1_last_x",       32'(lastx),    32'd799);
    check("d1_last_y",       32'(lasty),    32'd7);
    check("d1_wrap_frame_st", 32'(d1_fs),   32'd1);
    check("d1_wrap_x",        32'(d1_x),    32'd0);
    check("d1_wrap_y",        32'(d1_y),    32'd0);
    step();
    check("d1_wrap_frame_st_off", 32'(d1_fs), 32'd0);

    // ---------------- tiny raster, mid-frame reset ----------------
    rst2 = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      step();
      if (d2_x == 10'd5 && d2_y == 10'd2) found = 1'b1;
    end
    check("d2_reach_5_2", 32'(found), 32'd1);
    check("d2_hsync_at_x5", 32'(d2_hs), 32'd1);
    rst2 = 1'b1;
    step();
    check("d2_rst_x",        32'(d2_x),   32'd0);
    check("d2_rst_y",        32'(d2_y),   32'd0);
    check("d2_rst_hsync",    32'(d2_hs),  32'd0);
    check("d2_rst_vsync",    32'(d2_vs),  32'd1);
    check("d2_rst_video_on", 32'(d2_vid), 32'd0);
    check("d2_rst_pix_tick", 32'(d2_pt),  32'd0);
    check("d2_rst_line_st",  32'(d2_ls),  32'd0);
    check("d2_rst_frame_st", 32'(d2_fs),  32'd0);
    rst2 = 1'b0;
    step();
    check("d2_rel1_frame_st", 32'(d2_fs), 32'd0);
    step();
    check("d2_rel2_frame_st", 32'(d2_fs), 32'd0);
    step();
    check("d2_rel3_frame_st", 32'(d2_fs), 32'd1);
    check("d2_rel3_x",        32'(d2_x),  32'd0);
    check("d2_rel3_y",        32'(d2_y),  32'd0);

    clear_tallies();
    run = 3; bad_runs = 0; prevx = 0;
    for (int i = 1; i <= 144; i++) begin
      step();
      if (d2_ls) ls_n++;
      if (d2_fs) fs_n++;
      if (d2_vid) vid_n++;
      if (!d2_vs) vs_n++;
      if (d2_hs) begin
        hs_n++;
        if (int'(d2_x) < hs_xmin) hs_xmin = int'(d2_x);
        if (int'(d2_x) > hs_xmax) hs_xmax = int'(d2_x);
      end
      if (int'(d2_x) != prevx) begin
        if (run != 3) bad_runs++;
        run = 1;
        prevx = int'(d2_x);
      end else begin
        run++;
      end
      if (int'(d2_x) > xmax) xmax = int'(d2_x);
      if (int'(d2_y) > ymax) ymax = int'(d2_y);
    end
    check("d2_bad_pixel_runs", 32'(bad_runs), 32'd0);
    check("d2_line_st_cnt",    32'(ls_n),     32'd6);
    check("d2_frame_st_cnt",   32'(fs_n),     32'd1);
    check("d2_video_clks",     32'(vid_n),    32'd36);
    check("d2_vsync_clks",     32'(vs_n),     32'd24);
    check("d2_hsync_clks",     32'(hs_n),     32'd36);
    check("d2_hsync_xmin",     32'(hs_xmin),  32'd5);
    check("d2_hsync_xmax",     32'(hs_xmax),  32'd6);
    check("d2_x_max",          32'(xmax),     32'd7);
    check("d2_y_max",          32'(ymax),     32'd5);
    check("d2_end_frame_st",   32'(d2_fs),    32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
